// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   - rx_state_t   : receiver FSM states (IDLE, START, RECV, DONE)
//   - frame pieces : start/stop bit counts, 7/8 data-bit widths
//   - K_W          : width of the clocks-per-bit divisor
//   - frame_shifts : number of samples after the start bit (data+parity+stop)
//   - parity_err   : parity check of a received character
package uart_pkg;

  localparam int K_W         = 20;
  localparam int START_BITS  = 1;
  localparam int STOP_BITS   = 1;
  localparam int DATA_BITS_7 = 7;
  localparam int DATA_BITS_8 = 8;
  localparam int SHIFT_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RECV  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  // Samples taken after the start bit: data bits, optional parity, stop bit.
  function automatic logic [3:0] frame_shifts(input logic eight, input logic pen);
    return 4'(DATA_BITS_7) + {3'd0, eight} + {3'd0, pen} + 4'(STOP_BITS);
  endfunction

  // Bit 7 of a 7-bit character is zero, so it never disturbs the XOR.
  function automatic logic parity_err(input logic [7:0] d, input logic p,
                                      input logic pen, input logic ohel);
    return pen & ((^d ^ p) != ohel);
  endfunction

endpackage

// File: rtl/uart_receive_if.sv
// uart_receive_if: processor-side bundle of the UART receiver.
//   eight/pen/ohel/k : frame format and baud divisor
//   read             : one-cycle "character consumed" strobe
//   data/rxrdy       : received character and availability flag
//   perr/ferr/ovf    : parity, framing and overrun status
// modport master = processor, modport slave = receiver.
interface uart_receive_if;
  import uart_pkg::*;

  logic           eight;
  logic           pen;
  logic           ohel;
  logic [K_W-1:0] k;
  logic           read;
  logic [7:0]     data;
  logic           rxrdy;
  logic           perr;
  logic           ferr;
  logic           ovf;

  modport master (
    output eight, pen, ohel, k, read,
    input  data, rxrdy, perr, ferr, ovf
  );

  modport slave (
    input  eight, pen, ohel, k, read,
    output data, rxrdy, perr, ferr, ovf
  );

endinterface

// File: rtl/uart_rx_timer.sv
// uart_rx_timer: loadable down-counter timing half-bit and full-bit intervals.
//   clk, reset : clock, async active-high reset
//   load       : load load_val (takes priority over counting)
//   load_val   : interval length in clocks
//   expire     : high during the load_val-th cycle after the load edge
module uart_rx_timer
  import uart_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [K_W-1:0] load_val,
  output logic           expire
);

  logic [K_W-1:0] cnt_r;

  // Down-counter; parks at zero when no interval is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {K_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {K_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(K_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Firing on count 1 puts expiry exactly load_val cycles after the load.
  assign expire = (cnt_r == {{(K_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/uart_receive.sv
// uart_receive: UART receiver with mid-bit sampling and rxrdy/read handshake.
//   clk   : system clock (rising edge)
//   reset : asynchronous active-high reset
//   rx    : serial line, idle high, asynchronous
//   bus   : uart_receive_if.slave (format/divisor in, character and flags out)
// Build option: UART_RX_OVERRUN_EN enables the sticky overrun flag ovf;
// without it ovf is 0 and a new character silently overwrites the old one.
// The character and flags are latched on the edge that takes the stop
// sample; the following DONE cycle only lets the line settle before IDLE.
module uart_receive
  import uart_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  uart_receive_if.slave bus
);

  rx_state_t            state_r, state_nx_s;
  logic                 rx_meta_r, rx_s;
  logic                 eight_r, pen_r, ohel_r;
  logic [K_W-1:0]       k_r;
  logic [3:0]           bit_cnt_r;
  logic [SHIFT_W-1:0]   shift_r, shift_nx_s;
  logic [8:0]           justified_s;
  logic [3:0]           m_s;
  logic                 wait_high_r, start_s, last_s, tmr_expire_s;
  logic                 tmr_load_s, capture_s, shift_s, bit_clr_s, done_s;
  logic [K_W-1:0]       tmr_val_s;
  logic [7:0]           data_s, data_r;
  logic                 par_bit_s, rxrdy_r, perr_r, ferr_r, ovf_r;

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  uart_rx_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expire   (tmr_expire_s)
  );

  assign start_s    = ~wait_high_r & ~rx_s;
  assign m_s        = frame_shifts(eight_r, pen_r);
  assign last_s     = (bit_cnt_r == (m_s - 4'd1));
  assign shift_nx_s = {rx_s, shift_r[SHIFT_W-1:1]};
  // After m_s shifts the frame sits at the top; slide it down to bit 0.
  assign justified_s = 9'(shift_nx_s >> (4'd10 - m_s));
  assign data_s      = eight_r ? justified_s[7:0] : {1'b0, justified_s[6:0]};
  assign par_bit_s   = eight_r ? justified_s[8] : justified_s[7];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_s) state_nx_s = ST_START; else state_nx_s = ST_IDLE;
      ST_START: if (tmr_expire_s) state_nx_s = rx_s ? ST_IDLE : ST_RECV;
                else state_nx_s = ST_START;
      ST_RECV:  if (tmr_expire_s && last_s) state_nx_s = ST_DONE;
                else state_nx_s = ST_RECV;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // FSM control strobes for timer, shifter, bit counter and output latch.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = k_r;
    capture_s  = 1'b0;
    shift_s    = 1'b0;
    bit_clr_s  = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          capture_s  = 1'b1;
          tmr_load_s = 1'b1;
          tmr_val_s  = bus.k >> 1;
        end else begin
          capture_s  = 1'b0;
        end
      end
      ST_START: begin
        if (tmr_expire_s && !rx_s) begin
          tmr_load_s = 1'b1;
          bit_clr_s  = 1'b1;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_RECV: begin
        if (tmr_expire_s) begin
          shift_s    = 1'b1;
          done_s     = last_s;
          tmr_load_s = ~last_s;
        end else begin
          shift_s    = 1'b0;
        end
      end
      ST_DONE: done_s = 1'b0;
      default: done_s = 1'b0;
    endcase
  end

  // Frame format held from start detection to the end of the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eight_r <= 1'b0;
      pen_r   <= 1'b0;
      ohel_r  <= 1'b0;
      k_r     <= {K_W{1'b0}};
    end else if (capture_s) begin
      eight_r <= bus.eight;
      pen_r   <= bus.pen;
      ohel_r  <= bus.ohel;
      k_r     <= bus.k;
    end else begin
      k_r     <= k_r;
    end
  end

  // Bit counter and shift register for data/parity/stop samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= {SHIFT_W{1'b0}};
    end else if (bit_clr_s) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= {SHIFT_W{1'b0}};
    end else if (shift_s) begin
      bit_cnt_r <= bit_cnt_r + 4'd1;
      shift_r   <= shift_nx_s;
    end else begin
      shift_r   <= shift_r;
    end
  end

  // After a bad stop bit the line must go high before a start can count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_high_r <= 1'b0;
    end else if (done_s && !rx_s) begin
      wait_high_r <= 1'b1;
    end else if (rx_s) begin
      wait_high_r <= 1'b0;
    end else begin
      wait_high_r <= wait_high_r;
    end
  end

  // Character/flag latch; a completing frame beats a same-cycle read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r  <= 8'd0;
      rxrdy_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (done_s) begin
      data_r  <= data_s;
      rxrdy_r <= 1'b1;
      perr_r  <= parity_err(data_s, par_bit_s, pen_r, ohel_r);
      ferr_r  <= ~rx_s;
`ifdef UART_RX_OVERRUN_EN
      ovf_r   <= bus.read ? 1'b0 : (ovf_r | rxrdy_r);
`else
      ovf_r   <= 1'b0;
`endif
    end else if (bus.read) begin
      rxrdy_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      rxrdy_r <= rxrdy_r;
    end
  end

  assign bus.data  = data_r;
  assign bus.rxrdy = rxrdy_r;
  assign bus.perr  = perr_r;
  assign bus.ferr  = ferr_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed self-checking bench for uart_receive.
// Frames are driven LSB-first as {stop, [parity], data, start} bit vectors.
module tb_uart_receive;
  import uart_pkg::*;

`ifdef UART_RX_OVERRUN_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rx;
  uart_receive_if bus();

  uart_receive dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fall_cyc = 0;
  int   rise_cyc = -1;
  logic rxrdy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle number of each rxrdy rising edge.
  always @(negedge clk) begin
    if (bus.rxrdy === 1'b1 && rxrdy_q !== 1'b1) rise_cyc = cyc;
    rxrdy_q = bus.rxrdy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic e, input logic p, input logic o, input int kk);
    bus.eight = e;
    bus.pen   = p;
    bus.ohel  = o;
    bus.k     = 20'(kk);
  endtask

  // Drive nbits of a frame, kk clocks each; pulse read in cycle read_at.
  task automatic send(input logic [10:0] bits, input int nbits, input int kk, input int read_at);
    int j = 0;
    fall_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      for (int c = 0; c < kk; c++) begin
        bus.read = (j == read_at);
        @(posedge clk);
        #1;
        j++;
      end
    end
    bus.read = 1'b0;
  endtask

  task automatic do_read();
    bus.read = 1'b1;
    wait_cyc(1);
    bus.read = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    bus.read = 1'b0;
    cfg(1'b1, 1'b0, 1'b0, 10);
    wait_cyc(3);
    chk("reset_outputs", {20'd0, bus.data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf}, 32'd0);
    chk("reset_state", 32'(dut.state_r), 32'(ST_IDLE));
    reset = 1'b0;
    wait_cyc(5);

    // 8N1 0xA5 at k=10
    send({1'b1, 8'hA5, 1'b0}, 10, 10, -1);
    chk("a5_data", 32'(bus.data), 32'h0000_00A5);
    chk("a5_rxrdy", 32'(bus.rxrdy), 32'd1);
    chk("a5_perr_ferr", {30'd0, bus.perr, bus.ferr}, 32'd0);
    chk("a5_latency", 32'(rise_cyc - fall_cyc), 32'd98);
    do_read();
    chk("a5_read_clears", 32'(bus.rxrdy), 32'd0);

    // 7-bit odd parity 0x41 at k=16
    cfg(1'b0, 1'b1, 1'b1, 16);
    send({1'b1, 1'b1, 7'h41, 1'b0}, 10, 16, -1);
    chk("odd_ok_data", 32'(bus.data), 32'h0000_0041);
    chk("odd_ok_perr", 32'(bus.perr), 32'd0);
    chk("odd_ok_latency", 32'(rise_cyc - fall_cyc), 32'd155);
    do_read();
    send({1'b1, 1'b0, 7'h41, 1'b0}, 10, 16, -1);
    chk("odd_bad_perr", 32'(bus.perr), 32'd1);
    chk("odd_bad_data", 32'(bus.data), 32'h0000_0041);
    chk("odd_bad_rxrdy", 32'(bus.rxrdy), 32'd1);
    do_read();
    chk("perr_read_clears", {30'd0, bus.perr, bus.rxrdy}, 32'd0);
    cfg(1'b0, 1'b1, 1'b0, 16);
    send({1'b1, 1'b0, 7'h41, 1'b0}, 10, 16, -1);
    chk("even_ok_perr", {30'd0, bus.perr, bus.rxrdy}, 32'd1);
    do_read();

    // Framing error, then line held low: no retrigger
    cfg(1'b1, 1'b0, 1'b0, 10);
    send({1'b0, 8'h3C, 1'b0}, 10, 10, -1);
    chk("ferr_set", 32'(bus.ferr), 32'd1);
    chk("ferr_data", 32'(bus.data), 32'h0000_003C);
    do_read();
    wait_cyc(120);
    chk("ferr_no_retrigger", {30'd0, bus.rxrdy, bus.ferr}, 32'd0);
    rx = 1'b1;
    wait_cyc(5);
    send({1'b1, 8'h3C, 1'b0}, 10, 10, -1);
    chk("after_ferr_frame", {23'd0, bus.data, bus.rxrdy}, {23'd0, 8'h3C, 1'b1});
    chk("after_ferr_clear", 32'(bus.ferr), 32'd0);
    do_read();

    // False start: 3-clock low pulse
    send(11'd0, 1, 3, -1);
    rx = 1'b1;
    chk("false_start_detect", 32'(dut.state_r), 32'(ST_START));
    wait_cyc(5);
    chk("false_start_idle", 32'(dut.state_r), 32'(ST_IDLE));
    wait_cyc(120);
    chk("false_start_no_rxrdy", 32'(bus.rxrdy), 32'd0);

    // Two frames with no read between them
    send({1'b1, 8'h11, 1'b0}, 10, 10, -1);
    chk("ovr_first_rxrdy", {23'd0, bus.data, bus.rxrdy}, {23'd0, 8'h11, 1'b1});
    send({1'b1, 8'h22, 1'b0}, 10, 10, -1);
    chk("ovr_data", 32'(bus.data), 32'h0000_0022);
    chk("ovr_flag", 32'(bus.ovf), 32'(OVF_EXP));
    do_read();
    chk("ovr_read_clears", {30'd0, bus.ovf, bus.rxrdy}, 32'd0);

    // Read in the same cycle as the second completion
    send({1'b1, 8'h11, 1'b0}, 10, 10, -1);
    send({1'b1, 8'h22, 1'b0}, 10, 10, 97);
    chk("coll_rxrdy", 32'(bus.rxrdy), 32'd1);
    chk("coll_ovf", 32'(bus.ovf), 32'd0);
    chk("coll_data", 32'(bus.data), 32'h0000_0022);

    // Reset after the 4th data bit of 0x5A
    send({1'b1, 8'h5A, 1'b0}, 5, 10, -1);
    reset = 1'b1;
    wait_cyc(2);
    chk("midreset_outputs", {20'd0, bus.data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf}, 32'd0);
    chk("midreset_state", 32'(dut.state_r), 32'(ST_IDLE));
    rx = 1'b1;
    reset = 1'b0;
    wait_cyc(3);
    send({1'b1, 8'h5A, 1'b0}, 10, 10, -1);
    chk("post_reset_frame", {23'd0, bus.data, bus.rxrdy}, {23'd0, 8'h5A, 1'b1});
    chk("post_reset_flags", {29'd0, bus.perr, bus.ferr, bus.ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
